mac_saturante: RTL and testbench
================================

// Module: mac_saturante
// PURPOSE
//  Pipelined signed multiply-accumulate (dot product) of Length operand pairs.
//  Result is saturated or wrapped to Width bits, with a valid/ready handshake on both sides.
//  Successor to the combinational saturating multiplier: it adds a wide internal accumulator,
//  a selectable overflow mode and backpressure. It is the element engine of the 4x4 matrix multiplier.
// PARAMETERS
//  Width     8  signed operand and result width (>=2)
//  Length    4  products per result (>=1)
//  Saturate  1  1: clip result to [-2^(Width-1), 2^(Width-1)-1]; 0: keep low Width bits (wrap)
// PORTS
//  Clock      in   1      single clock; all state on rising edge
//  Reset      in   1      synchronous, active-high; clears all state
//  OperandoA  in   Width  signed, sampled on input handshake
//  OperandoB  in   Width  signed, sampled on input handshake
//  InValid    in   1      operand pair present
//  InReady    out  1      block accepts a pair this cycle
//  Result     out  Width  signed dot product; stable while OutValid=1
//  Error      out  1      result out of Width range (set in both modes); qualified by OutValid
//  OutValid   out  1      Result/Error valid
//  OutReady   in   1      consumer takes result this cycle
// BEHAVIOUR
//  - Reset: one clock, synchronous, active-high. All outputs reset to 0 (InReady too).
//    State goes to ACUM; counter, accumulator and product-valid are cleared.
//    InReady rises the cycle after Reset drops.
//  - Accumulator width: AccW = 2*Width + clog2(Length).
//    Products are full 2*Width precision and are sign-extended into the accumulator,
//    which therefore never overflows internally.
//  - Stage 1: when InValid&InReady, register P <= A*B (signed) and set Pv=1.
//    Otherwise Pv=0.
//  - Stage 2: when Pv=1, Acc <= Acc + sext(P).
//  - FSM states: ACUM, DRAIN, HOLD.
//    - ACUM: InReady=1. The element counter increments per accepted pair.
//      On acceptance of pair Length: go to DRAIN and reset the counter to 0.
//    - DRAIN: InReady=0. Stay until the last product is added (Pv=1 this cycle).
//      Then go to HOLD, registering Result=narrow(Acc+P) and Error.
//    - HOLD: OutValid=1, InReady=0. Result and Error are held.
//      On OutReady=1: OutValid=0, Acc<=0, go to ACUM (InReady=1 next cycle).
//  - Latency: last pair accepted at edge t; OutValid=1 from edge t+2.
//    Minimum period per result is Length+3 cycles with OutReady tied high.
//  - narrow(x):
//    - Saturate=1: if x > 2^(W-1)-1 then Result=2^(W-1)-1 and Error=1.
//      If x < -2^(W-1) then Result=-2^(W-1) and Error=1.
//      Otherwise Result=x[W-1:0] and Error=0.
//    - Saturate=0: Result=x[W-1:0]; Error uses the same range test.
//  - Intermediate sums beyond Width range are legal; only the final sum is narrowed.
//  - InValid while InReady=0 is ignored, with no side effect.
//    Operands need not be held.
//  - OutReady while OutValid=0 is ignored.
//  - Length=1: ACUM -> DRAIN after every accepted pair.
//  - Reset at any state, including mid-vector or in HOLD, discards the partial sum
//    and any pending result; no output is produced for that vector.
// STRUCTURE
//  - Shared include mac_defs.vh holds:
//    - constant function clog2
//    - FSM localparams ST_ACUM=2'd0, ST_DRAIN=2'd1, ST_HOLD=2'd2
//  - Sub-module saturador #(InW=AccW, OutW=Width, Saturate): combinational narrow();
//    outputs Result and Error.
//  - Top level holds the product register, accumulator, counter and FSM.
// TESTING (Width=8, Length=4 unless noted)
//  1. A={1,2,3,4}, B={5,6,7,8}, back-to-back
//     -> Result=70, Error=0; OutValid 2 cycles after the 4th accept.
//  2. A=B={127,127,127,127} -> sum 64516 -> Result=127, Error=1.
//     With Saturate=0 -> Result=4, Error=1.
//  3. A={-128 x4}, B={127 x4} -> sum -65024 -> Result=-128, Error=1.
//  4. A={100,100,-100,-100}, B={100 x4}
//     -> Result=0, Error=0 (intermediate 20000 must not clip).
//  5. OutReady=0 for 5 cycles in HOLD
//     -> OutValid=1, Result stable, InReady=0 throughout.
//     Pulse OutReady -> InReady=1 next cycle; next vector is unaffected.
//  6. Reset after 2 accepted pairs, then send vector 1
//     -> Result=70 (no residue). InValid pulses during DRAIN are not counted.

Source files
------------

// File: rtl/mac_saturante_pkg.sv
// Shared types and helpers for the saturating multiply-accumulate engine.
package mac_saturante_pkg;

    typedef enum logic [1:0] {
        ST_ACUM  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    // Ceiling log2; returns 0 for n <= 1.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        int unsigned v;
        r = 0;
        v = (n > 0) ? n - 1 : 0;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mac_saturante_saturador.sv
// Combinational narrowing of the wide accumulator sum to the result width,
// either clipping or wrapping; error flags any out-of-range value in both modes.
module mac_saturante_saturador
    import mac_saturante_pkg::*;
#(
    parameter int unsigned InW      = 18,
    parameter int unsigned OutW     = 8,
    parameter bit          Saturate = 1'b1
) (
    input  logic [InW-1:0]  value,
    output logic [OutW-1:0] result,
    output logic            error
);

    // In range exactly when every bit from the result sign bit upward agrees.
    logic [InW-OutW:0] upper;
    assign upper = value[InW-1:OutW-1];

    always_comb begin
        error  = !((&upper) || !(|upper));
        result = value[OutW-1:0];
        if (Saturate && error) begin
            result = value[InW-1] ? {1'b1, {(OutW-1){1'b0}}}
                                  : {1'b0, {(OutW-1){1'b1}}};
        end
    end

endmodule

// File: rtl/mac_saturante.sv
// Pipelined signed dot product of Length operand pairs with a wide accumulator,
// saturating or wrapping output and valid/ready handshakes on both sides.
module mac_saturante
    import mac_saturante_pkg::*;
#(
    parameter int unsigned Width    = 8,
    parameter int unsigned Length   = 4,
    parameter bit          Saturate = 1'b1
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [Width-1:0] OperandoA,
    input  logic [Width-1:0] OperandoB,
    input  logic             InValid,
    output logic             InReady,
    output logic [Width-1:0] Result,
    output logic             Error,
    output logic             OutValid,
    input  logic             OutReady
);

    localparam int unsigned ProdW = 2 * Width;
    localparam int unsigned LenW  = clog2(Length);
    localparam int unsigned AccW  = ProdW + LenW;
    localparam int unsigned CntW  = clog2(Length + 1);
    localparam logic [CntW-1:0] LastIdx = CntW'(Length - 1);

    state_t                   state, state_d;
    logic [CntW-1:0]          cnt, cnt_d;
    logic signed [ProdW-1:0]  prod, prod_d;
    logic                     pv;
    logic signed [AccW-1:0]   acc, acc_sum;
    logic                     accept;
    logic                     in_ready_d, out_valid_d;
    logic                     load_result, clear_acc;
    logic [Width-1:0]         sat_result;
    logic                     sat_error;

    assign accept  = InValid && InReady;
    assign prod_d  = ProdW'($signed(OperandoA)) * ProdW'($signed(OperandoB));
    assign acc_sum = acc + AccW'(prod);

    mac_saturante_saturador #(
        .InW      (AccW),
        .OutW     (Width),
        .Saturate (Saturate)
    ) u_saturador (
        .value  (acc_sum),
        .result (sat_result),
        .error  (sat_error)
    );

    // State register.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= ST_ACUM;
        end else begin
            state <= state_d;
        end
    end

    // Next state and control. OutValid rises one cycle after entering HOLD,
    // so the result register has settled before it is offered.
    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        load_result = 1'b0;
        clear_acc   = 1'b0;
        out_valid_d = 1'b0;
        case (state)
            ST_ACUM: begin
                if (accept) begin
                    if (cnt == LastIdx) begin
                        cnt_d   = '0;
                        state_d = ST_DRAIN;
                    end else begin
                        cnt_d = cnt + CntW'(1);
                    end
                end
            end
            ST_DRAIN: begin
                if (pv) begin
                    load_result = 1'b1;
                    state_d     = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (OutValid && OutReady) begin
                    clear_acc = 1'b1;
                    state_d   = ST_ACUM;
                end else begin
                    out_valid_d = 1'b1;
                end
            end
            default: state_d = ST_ACUM;
        endcase
        in_ready_d = (state_d == ST_ACUM);
    end

    // Product pipeline, accumulator, counter and registered outputs.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            cnt      <= '0;
            prod     <= '0;
            pv       <= 1'b0;
            acc      <= '0;
            InReady  <= 1'b0;
            OutValid <= 1'b0;
            Result   <= '0;
            Error    <= 1'b0;
        end else begin
            cnt      <= cnt_d;
            pv       <= accept;
            InReady  <= in_ready_d;
            OutValid <= out_valid_d;
            if (accept) begin
                prod <= prod_d;
            end
            if (clear_acc) begin
                acc <= '0;
            end else if (pv) begin
                acc <= acc_sum;
            end
            if (load_result) begin
                Result <= sat_result;
                Error  <= sat_error;
            end
        end
    end

endmodule

// File: tb/tb_mac_saturante.sv
// Scoreboard bench for mac_saturante: directed vectors against a saturating and a wrapping instance.
module tb_mac_saturante;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] a, b;
    logic       in_valid, out_ready;
    logic       in_ready0, in_ready1, ov0, ov1, err0, err1;
    logic [7:0] res0, res1;

    always #5 clk = ~clk;

    mac_saturante #(.Width(8), .Length(4), .Saturate(1'b1)) dut_sat (
        .Clock(clk), .Reset(rst), .OperandoA(a), .OperandoB(b),
        .InValid(in_valid), .InReady(in_ready0), .Result(res0), .Error(err0),
        .OutValid(ov0), .OutReady(out_ready)
    );

    mac_saturante #(.Width(8), .Length(4), .Saturate(1'b0)) dut_wrap (
        .Clock(clk), .Reset(rst), .OperandoA(a), .OperandoB(b),
        .InValid(in_valid), .InReady(in_ready1), .Result(res1), .Error(err1),
        .OutValid(ov1), .OutReady(out_ready)
    );

    typedef struct packed {
        logic [7:0] r;
        logic       e;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   last_accept = -100;
    bit   lat_armed = 1'b0;
    logic ov_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compare every delivered result with the head of its queue.
    always @(negedge clk) begin
        exp_t e;
        if (ov0 && !ov_prev && lat_armed) begin
            check("latency", cyc, last_accept + 2);
            lat_armed = 1'b0;
        end
        ov_prev = ov0;
        if (!rst && ov0 && out_ready) begin
            if (q0.size() == 0) begin
                tests++; fails++;
                $display("FAIL unexpected_result_sat: got %0d, expected none", $signed(res0));
            end else begin
                e = q0.pop_front();
                check("result_sat", $signed(res0), $signed(e.r));
                check("error_sat", int'(err0), int'(e.e));
            end
        end
        if (!rst && ov1 && out_ready) begin
            if (q1.size() == 0) begin
                tests++; fails++;
                $display("FAIL unexpected_result_wrap: got %0d, expected none", $signed(res1));
            end else begin
                e = q1.pop_front();
                check("result_wrap", $signed(res1), $signed(e.r));
                check("error_wrap", int'(err1), int'(e.e));
            end
        end
    end

    // Offer n pairs; element i is byte i of av/bv. Called and returns at posedge+1.
    task automatic send_pairs(input logic [31:0] av, input logic [31:0] bv, input int n);
        bit accepted;
        for (int i = 0; i < n; i++) begin
            a = av[i*8 +: 8];
            b = bv[i*8 +: 8];
            in_valid = 1'b1;
            accepted = 1'b0;
            for (int k = 0; k < 200 && !accepted; k++) begin
                @(negedge clk);
                if (in_ready0) accepted = 1'b1;
                @(posedge clk); #1;
            end
            if (!accepted) begin
                tests++; fails++;
                $display("FAIL accept_timeout: pair %0d not accepted within 200 cycles", i);
            end
            last_accept = cyc;
        end
        in_valid = 1'b0;
    endtask

    task automatic send_vec(input logic [31:0] av, input logic [31:0] bv,
                            input logic [7:0] rs, input logic es,
                            input logic [7:0] rw, input logic ew);
        q0.push_back('{r: rs, e: es});
        q1.push_back('{r: rw, e: ew});
        send_pairs(av, bv, 4);
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 100 && (q0.size() != 0 || q1.size() != 0); k++) begin
            @(posedge clk); #1;
        end
        tests++;
        if (q0.size() != 0 || q1.size() != 0) begin
            fails++;
            $display("FAIL drain_timeout: %0d/%0d results outstanding, expected 0", q0.size(), q1.size());
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    localparam logic [31:0] V1A = {8'd4, 8'd3, 8'd2, 8'd1};
    localparam logic [31:0] V1B = {8'd8, 8'd7, 8'd6, 8'd5};

    initial begin
        bit seen;
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; out_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        check("reset_in_ready", int'(in_ready0), 0);
        check("reset_out_valid", int'(ov0), 0);
        check("reset_result", int'(res0), 0);
        check("reset_error", int'(err0), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("in_ready_held_after_reset_edge", int'(in_ready0), 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("in_ready_after_release", int'(in_ready0), 1);
        @(posedge clk); #1;

        // Basic dot product with latency check, then overflow and boundary sums.
        send_vec(V1A, V1B, 8'd70, 1'b0, 8'd70, 1'b0);
        lat_armed = 1'b1;
        send_vec(32'h7F7F7F7F, 32'h7F7F7F7F, 8'h7F, 1'b1, 8'h04, 1'b1);
        send_vec(32'h80808080, 32'h7F7F7F7F, 8'h80, 1'b1, 8'h00, 1'b1);
        send_vec({8'h9C, 8'h9C, 8'd100, 8'd100}, 32'h64646464, 8'h00, 1'b0, 8'h00, 1'b0);
        send_vec({8'd0, 8'd0, 8'd0, 8'd127}, 32'h01010101, 8'h7F, 1'b0, 8'h7F, 1'b0);
        send_vec({8'd0, 8'd0, 8'd64, 8'd64}, {8'd0, 8'd0, 8'd1, 8'd1}, 8'h7F, 1'b1, 8'h80, 1'b1);
        send_vec({8'd0, 8'd0, 8'hC0, 8'hC0}, {8'd0, 8'd0, 8'd1, 8'd1}, 8'h80, 1'b0, 8'h80, 1'b0);
        send_vec({8'd1, 8'd0, 8'hFA, 8'hFB}, 32'h0A0A0A0A, 8'h9C, 1'b0, 8'h9C, 1'b0);
        wait_idle();

        // Backpressure: result held for 5 cycles, then a single-cycle OutReady pulse.
        out_ready = 1'b0;
        send_vec(V1A, V1B, 8'd70, 1'b0, 8'd70, 1'b0);
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (ov0) seen = 1'b1;
        end
        check("hold_out_valid_seen", int'(seen), 1);
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            check("hold_out_valid", int'(ov0), 1);
            check("hold_result_stable", $signed(res0), 70);
            check("hold_in_ready", int'(in_ready0), 0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        check("release_in_ready", int'(in_ready0), 1);
        check("release_out_valid", int'(ov0), 0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        send_vec(32'h7F7F7F7F, 32'h7F7F7F7F, 8'h7F, 1'b1, 8'h04, 1'b1);
        wait_idle();

        // Reset mid-vector discards the partial sum.
        send_pairs(32'h7F7F7F7F, 32'h7F7F7F7F, 2);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("midreset_in_ready", int'(in_ready0), 0);
        check("midreset_out_valid", int'(ov0), 0);
        @(posedge clk); #1;
        send_vec(V1A, V1B, 8'd70, 1'b0, 8'd70, 1'b0);
        // Operands offered while the block is draining must be ignored.
        a = 8'd50; b = 8'd50; in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        send_vec(V1A, V1B, 8'd70, 1'b0, 8'd70, 1'b0);
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
